// File: rtl/tpu_top.sv
// 8-bit matrix-multiply TPU: C = A * B on a 4x4 output-stationary systolic array.
// Operands stream from GBUFF_A/GBUFF_B; each finished tile is written row by row to GBUFF_OUT.

module tpu_gbuff #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 256,
    parameter int AW        = $clog2(ADDR_SIZE)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_addr,
    input  logic [WORD_SIZE-1:0] i_din,
    output logic [WORD_SIZE-1:0] o_dout
);

    logic [WORD_SIZE-1:0] gbuff [ADDR_SIZE];

    always_ff @(posedge clk) begin
        if (i_we) gbuff[i_addr] <= i_din;
        o_dout <= gbuff[i_addr];
    end

endmodule

module tpu_top #(
    parameter int DATA_SIZE = 8,
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] m,
    input  logic [3:0] k,
    input  logic [3:0] n,
    output logic       done
);

    localparam int AW = $clog2(ADDR_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_TILE,
        S_FEED,
        S_WRITE,
        S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [3:0] r_m, r_k, r_n;
    logic [1:0] r_p, r_q, r_w;
    logic [4:0] r_f;
    logic       r_rd_vld_p0;

    logic           w_issue, w_p_last, w_q_last, w_wr_last, w_feed_end, w_zero_dim;
    logic [3:0]     w_row;
    logic [4:0]     w_rd_t;
    logic [AW-1:0]  w_a_addr, w_b_addr, w_o_addr;
    logic           w_o_we;
    logic [WORD_SIZE-1:0] w_a_dout, w_b_dout, w_o_din, w_unused_out_dout;

    logic signed [DATA_SIZE-1:0] w_a_byte [4];
    logic signed [DATA_SIZE-1:0] w_b_byte [4];
    logic signed [DATA_SIZE-1:0] w_a_edge [4];
    logic signed [DATA_SIZE-1:0] w_b_edge [4];
    logic signed [DATA_SIZE-1:0] w_a_in   [4][4];
    logic signed [DATA_SIZE-1:0] w_b_in   [4][4];

    logic signed [DATA_SIZE-1:0] r_ska1_p1, r_ska2_p1, r_ska2_p2, r_ska3_p1, r_ska3_p2, r_ska3_p3;
    logic signed [DATA_SIZE-1:0] r_skb1_p1, r_skb2_p1, r_skb2_p2, r_skb3_p1, r_skb3_p2, r_skb3_p3;
    logic signed [DATA_SIZE-1:0] r_a_pass [4][4];
    logic signed [DATA_SIZE-1:0] r_b_pass [4][4];
    logic signed [DATA_SIZE-1:0] r_acc    [4][4];

    // Product and sum both wrap modulo 2^DATA_SIZE; only the low byte is kept.
    function automatic logic signed [DATA_SIZE-1:0] mac_wrap(
        input logic signed [DATA_SIZE-1:0] acc,
        input logic signed [DATA_SIZE-1:0] a,
        input logic signed [DATA_SIZE-1:0] b
    );
        logic signed [2*DATA_SIZE-1:0] prod;
        prod = a * b;
        return acc + prod[DATA_SIZE-1:0];
    endfunction

    assign w_zero_dim = (m == 4'd0) || (k == 4'd0) || (n == 4'd0);
    assign w_row      = {r_p, 2'b00} + {2'b00, r_w};
    assign w_wr_last  = (r_w == 2'd3) || (w_row + 4'd1 >= r_m);
    assign w_p_last   = ({1'b0, r_p, 2'b00} + 5'd4) >= {1'b0, r_m};
    assign w_q_last   = ({1'b0, r_q, 2'b00} + 5'd4) >= {1'b0, r_n};
    assign w_feed_end = (r_f == ({1'b0, r_k} + 5'd5));
    assign w_issue    = (r_state == S_LOAD_TILE) ||
                        ((r_state == S_FEED) && ((r_f + 5'd1) < {1'b0, r_k}));
    assign w_rd_t     = (r_state == S_LOAD_TILE) ? 5'd0 : (r_f + 5'd1);

    assign w_a_addr = AW'(r_p) * AW'(r_k) + AW'(w_rd_t);
    assign w_b_addr = AW'(r_q) * AW'(r_k) + AW'(w_rd_t);
    assign w_o_addr = AW'(r_q) * AW'(r_m) + AW'(w_row);
    assign w_o_we   = (r_state == S_WRITE);
    assign done     = (r_state == S_DONE);

    tpu_gbuff #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) GBUFF_A (
        .clk(clk), .i_we(1'b0), .i_addr(w_a_addr), .i_din('0), .o_dout(w_a_dout)
    );
    tpu_gbuff #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) GBUFF_B (
        .clk(clk), .i_we(1'b0), .i_addr(w_b_addr), .i_din('0), .o_dout(w_b_dout)
    );
    tpu_gbuff #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) GBUFF_OUT (
        .clk(clk), .i_we(w_o_we), .i_addr(w_o_addr), .i_din(w_o_din), .o_dout(w_unused_out_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_nxt = w_zero_dim ? S_DONE : S_LOAD_TILE;
            S_LOAD_TILE: w_state_nxt = S_FEED;
            S_FEED:      if (w_feed_end) w_state_nxt = S_WRITE;
            S_WRITE:     if (w_wr_last) w_state_nxt = (w_p_last && w_q_last) ? S_DONE : S_LOAD_TILE;
            S_DONE:      w_state_nxt = S_DONE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m <= '0; r_k <= '0; r_n <= '0;
            r_p <= '0; r_q <= '0; r_w <= '0;
            r_f <= '0;
            r_rd_vld_p0 <= 1'b0;
        end else begin
            r_rd_vld_p0 <= w_issue;
            case (r_state)
                S_IDLE: if (start) begin
                    r_m <= m; r_k <= k; r_n <= n;
                    r_p <= '0; r_q <= '0;
                end
                S_LOAD_TILE: begin
                    r_f <= '0;
                    r_w <= '0;
                end
                S_FEED:  r_f <= r_f + 5'd1;
                S_WRITE: begin
                    r_w <= r_w + 2'd1;
                    if (w_wr_last) begin
                        if (w_q_last) begin
                            r_q <= '0;
                            r_p <= r_p + 2'd1;
                        end else begin
                            r_q <= r_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // p0: buffer read data, zeroed outside the k valid steps
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_a_byte[i] = r_rd_vld_p0 ? w_a_dout[WORD_SIZE-1-DATA_SIZE*i -: DATA_SIZE] : '0;
            w_b_byte[i] = r_rd_vld_p0 ? w_b_dout[WORD_SIZE-1-DATA_SIZE*i -: DATA_SIZE] : '0;
        end
    end

    // p1..p3: row i / column j skew delays of i / j cycles
    assign w_a_edge[0] = w_a_byte[0];
    assign w_a_edge[1] = r_ska1_p1;
    assign w_a_edge[2] = r_ska2_p2;
    assign w_a_edge[3] = r_ska3_p3;
    assign w_b_edge[0] = w_b_byte[0];
    assign w_b_edge[1] = r_skb1_p1;
    assign w_b_edge[2] = r_skb2_p2;
    assign w_b_edge[3] = r_skb3_p3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_a_in[i][0] = w_a_edge[i];
            w_b_in[0][i] = w_b_edge[i];
            for (int j = 1; j < 4; j++) begin
                w_a_in[i][j] = r_a_pass[i][j-1];
                w_b_in[j][i] = r_b_pass[j-1][i];
            end
        end
    end

    // Array: operands hop one PE per cycle; accumulators run only while feeding
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_LOAD_TILE)) begin
            r_ska1_p1 <= '0; r_ska2_p1 <= '0; r_ska2_p2 <= '0;
            r_ska3_p1 <= '0; r_ska3_p2 <= '0; r_ska3_p3 <= '0;
            r_skb1_p1 <= '0; r_skb2_p1 <= '0; r_skb2_p2 <= '0;
            r_skb3_p1 <= '0; r_skb3_p2 <= '0; r_skb3_p3 <= '0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_a_pass[i][j] <= '0;
                    r_b_pass[i][j] <= '0;
                    r_acc[i][j]    <= '0;
                end
            end
        end else if (r_state == S_FEED) begin
            r_ska1_p1 <= w_a_byte[1];
            r_ska2_p1 <= w_a_byte[2];
            r_ska2_p2 <= r_ska2_p1;
            r_ska3_p1 <= w_a_byte[3];
            r_ska3_p2 <= r_ska3_p1;
            r_ska3_p3 <= r_ska3_p2;
            r_skb1_p1 <= w_b_byte[1];
            r_skb2_p1 <= w_b_byte[2];
            r_skb2_p2 <= r_skb2_p1;
            r_skb3_p1 <= w_b_byte[3];
            r_skb3_p2 <= r_skb3_p1;
            r_skb3_p3 <= r_skb3_p2;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_a_pass[i][j] <= w_a_in[i][j];
                    r_b_pass[i][j] <= w_b_in[i][j];
                    r_acc[i][j]    <= mac_wrap(r_acc[i][j], w_a_in[i][j], w_b_in[i][j]);
                end
            end
        end
    end

    // Output word is LSB-byte-first; columns past n are padded with zero
    always_comb begin
        w_o_din = '0;
        for (int j = 0; j < 4; j++) begin
            if (({r_q, 2'b00} + 4'(j)) < r_n)
                w_o_din[DATA_SIZE*j +: DATA_SIZE] = r_acc[r_w][j];
        end
    end

endmodule

// File: tb/tb_tpu_top.sv
// Directed bench for tpu_top: identity, wrap-around, odd and maximum sizes, hold and mid-run reset.

module tb_tpu_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] m = '0, k = '0, n = '0;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] A [12][15];
    logic [7:0] B [15][12];

    localparam logic [31:0] SENT = 32'hDEADBEEF;

    always #5 clk = ~clk;

    tpu_top dut (
        .clk(clk), .rst(rst), .start(start),
        .m(m), .k(k), .n(n), .done(done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_out();
        for (int i = 0; i < 256; i++) dut.GBUFF_OUT.gbuff[i] = SENT;
    endtask

    task automatic load_bufs(input int kk);
        for (int p = 0; p < 3; p++)
            for (int t = 0; t < kk; t++)
                dut.GBUFF_A.gbuff[p*kk+t] = {A[4*p][t], A[4*p+1][t], A[4*p+2][t], A[4*p+3][t]};
        for (int q = 0; q < 3; q++)
            for (int t = 0; t < kk; t++)
                dut.GBUFF_B.gbuff[q*kk+t] = {B[t][4*q], B[t][4*q+1], B[t][4*q+2], B[t][4*q+3]};
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int r = 0; r < 12; r++) for (int t = 0; t < 15; t++) A[r][t] = v;
        for (int t = 0; t < 15; t++) for (int c = 0; c < 12; c++) B[t][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 12; r++) for (int t = 0; t < 15; t++) A[r][t] = 8'($urandom);
        for (int t = 0; t < 15; t++) for (int c = 0; c < 12; c++) B[t][c] = 8'($urandom);
    endtask

    task automatic run_op(input string tag, input int mm, input int kk, input int nn, input int bound);
        int cyc;
        @(negedge clk);
        m = 4'(mm); k = 4'(kk); n = 4'(nn); start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 1000);
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_latency_ok"}, 32'(cyc <= bound), 32'd1);
    endtask

    function automatic logic [31:0] exp_word(input int q, input int r, input int kk, input int nn);
        logic [31:0] w;
        int s, c;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            c = 4*q + j;
            if (c < nn) begin
                s = 0;
                for (int t = 0; t < kk; t++) s += int'(A[r][t]) * int'(B[t][c]);
                w[8*j +: 8] = 8'(s % 256);
            end
        end
        return w;
    endfunction

    task automatic check_out(input string tag, input int mm, input int kk, input int nn);
        int qn;
        qn = (nn + 3) / 4;
        for (int q = 0; q < qn; q++)
            for (int r = 0; r < mm; r++)
                check_eq($sformatf("%s_q%0d_r%0d", tag, q, r),
                         dut.GBUFF_OUT.gbuff[q*mm+r], exp_word(q, r, kk, nn));
        check_eq({tag, "_untouched0"}, dut.GBUFF_OUT.gbuff[qn*mm],   SENT);
        check_eq({tag, "_untouched1"}, dut.GBUFF_OUT.gbuff[qn*mm+1], SENT);
    endtask

    logic [31:0] id_exp [4];

    initial begin
        id_exp[0] = 32'h04030201;
        id_exp[1] = 32'h08070605;
        id_exp[2] = 32'h0C0B0A09;
        id_exp[3] = 32'h100F0E0D;

        do_reset();
        check_eq("reset_done", 32'(done), 32'd0);

        // Identity A, B = 1..16 row-major
        fill_const(8'h00);
        for (int i = 0; i < 4; i++) A[i][i] = 8'h01;
        for (int t = 0; t < 4; t++) for (int c = 0; c < 4; c++) B[t][c] = 8'(4*t + c + 1);
        fill_out();
        load_bufs(4);
        run_op("ident", 4, 4, 4, 26);
        for (int r = 0; r < 4; r++)
            check_eq($sformatf("ident_r%0d", r), dut.GBUFF_OUT.gbuff[r], id_exp[r]);
        check_eq("ident_untouched", dut.GBUFF_OUT.gbuff[4], SENT);

        // Hold start after done with A cleared: a rerun would zero the results
        for (int i = 0; i < 4; i++) dut.GBUFF_A.gbuff[i] = 32'h0;
        @(negedge clk);
        start = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("hold_done", 32'(done), 32'd1);
        for (int r = 0; r < 4; r++)
            check_eq($sformatf("hold_r%0d", r), dut.GBUFF_OUT.gbuff[r], id_exp[r]);
        start = 1'b0;

        // Wrap: 4 * 0x10*0x10 = 0x400 -> 0x00
        do_reset();
        check_eq("reset2_done", 32'(done), 32'd0);
        fill_const(8'h10);
        fill_out();
        load_bufs(4);
        run_op("wrap10", 4, 4, 4, 26);
        for (int r = 0; r < 4; r++)
            check_eq($sformatf("wrap10_r%0d", r), dut.GBUFF_OUT.gbuff[r], 32'h00000000);

        // Wrap: 4 * 3*3 = 36 = 0x24
        do_reset();
        fill_const(8'h03);
        fill_out();
        load_bufs(4);
        run_op("wrap03", 4, 4, 4, 26);
        for (int r = 0; r < 4; r++)
            check_eq($sformatf("wrap03_r%0d", r), dut.GBUFF_OUT.gbuff[r], 32'h24242424);

        // Odd sizes: partial row tile and column padding
        do_reset();
        fill_rand();
        fill_out();
        load_bufs(3);
        run_op("odd", 5, 3, 6, 76);
        check_out("odd", 5, 3, 6);
        for (int r = 0; r < 5; r++)
            check_eq($sformatf("odd_pad_r%0d", r), 32'(dut.GBUFF_OUT.gbuff[5+r][31:16]), 32'h0);

        // Largest legal shape
        do_reset();
        fill_rand();
        fill_out();
        load_bufs(15);
        run_op("max", 12, 15, 12, 269);
        check_out("max", 12, 15, 12);

        // Zero dimensions finish with no writes
        do_reset();
        fill_out();
        run_op("zero_m", 0, 4, 4, 8);
        check_eq("zero_m_untouched", dut.GBUFF_OUT.gbuff[0], SENT);
        do_reset();
        run_op("zero_k", 4, 0, 4, 8);
        check_eq("zero_k_untouched", dut.GBUFF_OUT.gbuff[0], SENT);

        // Reset during FEED aborts; a later start recomputes
        do_reset();
        fill_const(8'h03);
        fill_out();
        load_bufs(4);
        @(negedge clk);
        m = 4'd4; k = 4'd4; n = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_done", 32'(done), 32'd0);
        repeat (30) @(negedge clk);
        check_eq("abort_idle_done", 32'(done), 32'd0);
        check_eq("abort_no_write", dut.GBUFF_OUT.gbuff[0], SENT);
        run_op("rerun", 4, 4, 4, 26);
        for (int r = 0; r < 4; r++)
            check_eq($sformatf("rerun_r%0d", r), dut.GBUFF_OUT.gbuff[r], 32'h24242424);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
